// File: rtl/ic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ic_pkg
// Purpose  : Shared constants for the interrupt controller: register address
//            map for the software port and the request-FSM state encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ic_pkg;

    // Register select values presented on addr
    localparam logic [1:0] IC_MASK = 2'd0;
    localparam logic [1:0] IC_PEND = 2'd1;
    localparam logic [1:0] IC_VEC  = 2'd2;
    localparam logic [1:0] IC_EDGE = 2'd3;

    // Request FSM encodings
    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_REQ  = 2'd1;
    localparam logic [STATE_W-1:0] ST_SVC  = 2'd2;

endpackage : ic_pkg
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
// Module   : irq_sync
// Purpose  : Per-bit two-flop synchronizer for asynchronous interrupt inputs,
//            followed by a one-cycle-delayed copy used for rising-edge
//            detection.
// Ports    : clk      in  1  rising-edge clock
//            rst      in  1  synchronous reset, active-high
//            i_async  in  W  raw asynchronous inputs
//            o_sync   out W  synchronized inputs (second flop)
//            o_rise   out W  high for one cycle after o_sync goes 0->1
// Revision : 1.0 - initial release
// ============================================================================
module irq_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;

endmodule : irq_sync
`default_nettype wire

// File: rtl/intr_controller.sv
`default_nettype none
// ============================================================================
// Module   : intr_controller
// Purpose  : Interrupt-request side of the CPU interrupt handshake. Gathers
//            N_SRC sources through a synchronizer, latches them as pending
//            (edge or level per source), masks and priority-encodes them,
//            raises intr until the CPU acknowledges with inta, and then holds
//            intr low until software signals end-of-interrupt.
// Ports    : clk      in  1      rising-edge clock
//            rst      in  1      synchronous reset, active-high
//            irq_src  in  N_SRC  raw interrupt sources (asynchronous)
//            inta     in  1      CPU acknowledge pulse
//            eoi      in  1      end-of-interrupt pulse
//            we       in  1      register write strobe
//            addr     in  2      register select (MASK/PENDING/VECTOR/EDGE)
//            wdata    in  32     register write data
//            rdata    out 32     register read data (combinational)
//            intr     out 1      interrupt request to CPU
//            vec      out VEC_W  index of the source in service
// Revision : 1.0 - initial release
// ============================================================================
module intr_controller
    import ic_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int VEC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             inta,
    input  logic             eoi,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             intr,
    output logic [VEC_W-1:0] vec
);

    logic [N_SRC-1:0]   w_s2;
    logic [N_SRC-1:0]   w_rise;
    logic [N_SRC-1:0]   r_pend;
    logic [N_SRC-1:0]   r_mask;
    logic [N_SRC-1:0]   r_edge;
    logic [VEC_W-1:0]   r_vec;
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;

    logic [N_SRC-1:0]   w_active;
    logic               w_any;
    logic [VEC_W-1:0]   w_sel;
    logic               w_take;
    logic [N_SRC-1:0]   w_w1c;
    logic [N_SRC-1:0]   w_grant_clr;
    logic               w_unused;

    // Upper write-data bits have no home in any register.
    assign w_unused = &{1'b0, wdata[31:N_SRC]};

    irq_sync #(
        .W (N_SRC)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (irq_src),
        .o_sync  (w_s2),
        .o_rise  (w_rise)
    );

    assign w_active = r_pend & r_mask;
    assign w_any    = |w_active;

    // Lowest set index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        w_sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_sel = i[VEC_W-1:0];
            end
        end
    end

    // Acknowledge taken in REQ; this beats both eoi and a vanished request.
    assign w_take = (r_state == ST_REQ) && inta;

    // W1C only reaches edge-mode bits; level bits just follow the source.
    assign w_w1c = (we && (addr == IC_PEND)) ? (wdata[N_SRC-1:0] & r_edge) : '0;

    // Grant consumes an edge-mode pending bit. The any-check keeps an
    // acknowledge against an empty active set from clearing bit 0.
    assign w_grant_clr = (w_take && w_any) ? (({{(N_SRC-1){1'b0}}, 1'b1} << w_sel) & r_edge)
                                           : '0;

    // Pending: a fresh rising edge outranks any clear in the same cycle.
    // The old edge-select value is used so an EDGE write takes effect next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (r_edge[i]) begin
                    if (w_rise[i]) begin
                        r_pend[i] <= 1'b1;
                    end else if (w_w1c[i] || w_grant_clr[i]) begin
                        r_pend[i] <= 1'b0;
                    end
                end else begin
                    r_pend[i] <= w_s2[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
            r_edge <= '0;
        end else if (we) begin
            if (addr == IC_MASK) begin
                r_mask <= wdata[N_SRC-1:0];
            end
            if (addr == IC_EDGE) begin
                r_edge <= wdata[N_SRC-1:0];
            end
        end
    end

    // vec only moves on a grant and otherwise holds the last serviced index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec <= '0;
        end else if (w_take) begin
            r_vec <= w_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (inta) begin
                    w_state_nxt = ST_SVC;
                end else if (!w_any) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SVC: begin
                if (eoi) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rdata = '0;
        case (addr)
            IC_MASK: rdata[N_SRC-1:0] = r_mask;
            IC_PEND: rdata[N_SRC-1:0] = r_pend;
            IC_VEC: begin
                rdata[31]        = (r_state == ST_SVC);
                rdata[VEC_W-1:0] = r_vec;
            end
            default: rdata[N_SRC-1:0] = r_edge;
        endcase
    end

    assign intr = (r_state == ST_REQ);
    assign vec  = r_vec;

endmodule : intr_controller
`default_nettype wire
